// File: rtl/adder_check_pkg.sv
// Shared encodings and default sizing for adder_datapath and its response checker.
package adder_check_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_LATENCY = 2;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/exp_delay_line.sv
// Fixed-depth shift register carrying {valid, expected} entries; MSB of each entry is its valid bit.
module exp_delay_line #(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] tail_o,
  output logic         any_valid_c_o
);

  logic [DEPTH-1:0][W-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (flush_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_o = stage_q[DEPTH-1];

  // True while any entry is still travelling toward the compare point.
  always_comb begin
    any_valid_c_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid_c_o = any_valid_c_o | stage_q[i][W-1];
    end
  end

endmodule

// File: rtl/adder_result_checker.sv
// Compares adder_datapath results against a delayed a+b+c model, counting vectors and mismatches per run.
module adder_result_checker
  import adder_check_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act
);

  localparam int unsigned EW = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] err_q, err_d, vec_q, vec_d;
  logic [WIDTH-1:0] fexp_q, fexp_d, fact_q, fact_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             pass_q, pass_d, fail_q, fail_d;

  logic             push_c;
  logic [WIDTH-1:0] sum_c;
  logic [EW-1:0]    tail_c;
  logic             tail_valid_c;
  logic [WIDTH-1:0] tail_exp_c;
  logic             mismatch_c;
  logic             pipe_busy_c;

  // A start in the same cycle wins over the vector, so it is never pushed.
  assign push_c = in_valid && !start && (state_q == ST_RUN);
  assign sum_c  = a + b + c;

  exp_delay_line #(
    .W     (EW),
    .DEPTH (LATENCY)
  ) u_exp_delay (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (start),
    .data_i        ({push_c, sum_c}),
    .tail_o        (tail_c),
    .any_valid_c_o (pipe_busy_c)
  );

  assign tail_valid_c = tail_c[WIDTH];
  assign tail_exp_c   = tail_c[WIDTH-1:0];
  assign mismatch_c   = tail_valid_c && (y != tail_exp_c);

  // Next-state, counters and first-error capture.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    vec_d   = vec_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;

    if (start) begin
      state_d = ST_RUN;
      err_d   = '0;
      vec_d   = '0;
      fexp_d  = '0;
      fact_d  = '0;
      ferr_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (in_valid && last) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pipe_busy_c) begin
            state_d = ST_DONE;
            pass_d  = (err_q == '0);
            fail_d  = (err_q != '0);
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase

      if (tail_valid_c) begin
        if (vec_q != CNT_MAX) vec_d = vec_q + CNT_W'(1);
        if (mismatch_c) begin
          if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
          if (!ferr_q) begin
            ferr_d = 1'b1;
            fexp_d = tail_exp_c;
            fact_d = y;
          end
        end
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      vec_q   <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign error_count = err_q;
  assign vec_count   = vec_q;
  assign first_exp   = fexp_q;
  assign first_act   = fact_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: cycle model of the checker plus a bench-side datapath delay for y.
module tb_adder_result_checker;
  import adder_check_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, last = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, y = '0;

  logic busy, done, pass, fail;
  logic [15:0] error_count, vec_count;
  logic [W-1:0] first_exp, first_act;
  logic busy4, done4, pass4, fail4;
  logic [3:0] error_count4, vec_count4;
  logic [W-1:0] first_exp4, first_act4;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(W), .LATENCY(L), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .last(last),
    .a(a), .b(b), .c(c), .y(y),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .error_count(error_count), .vec_count(vec_count),
    .first_exp(first_exp), .first_act(first_act)
  );

  adder_result_checker #(.WIDTH(W), .LATENCY(L), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .last(last),
    .a(a), .b(b), .c(c), .y(y),
    .busy(busy4), .done(done4), .pass(pass4), .fail(fail4),
    .error_count(error_count4), .vec_count(vec_count4),
    .first_exp(first_exp4), .first_act(first_act4)
  );

  typedef struct packed { logic [15:0] a, b, c, sum, mask; } vec_t;
  typedef struct packed { logic v; logic [15:0] act; } yl_t;
  typedef struct packed { logic [15:0] exp_v, act; } sb_t;

  yl_t yline [L+1];
  sb_t sbq [$];

  state_e      m_state;
  int unsigned m_vec, m_err, m_vec4, m_err4;
  logic        m_ferr;
  logic [15:0] m_fexp, m_fact;

  int n_vec = 0;
  int n_bad = 0;

  vec_t clean_tbl [3];
  vec_t strm_tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input state_e st);
    m_state = st;
    m_vec = 0; m_err = 0; m_vec4 = 0; m_err4 = 0;
    m_ferr = 1'b0; m_fexp = '0; m_fact = '0;
    for (int i = 0; i <= int'(L); i++) yline[i] = '0;
    sbq.delete();
  endtask

  task automatic check_all();
    logic md, mb;
    md = (m_state == ST_DONE);
    mb = (m_state == ST_RUN) || (m_state == ST_DRAIN);
    chk("busy", 32'(busy), 32'(mb));
    chk("done", 32'(done), 32'(md));
    chk("pass", 32'(pass), 32'(md && m_err == 0));
    chk("fail", 32'(fail), 32'(md && m_err != 0));
    chk("vec_count", 32'(vec_count), m_vec);
    chk("error_count", 32'(error_count), m_err);
    chk("first_exp", 32'(first_exp), 32'(m_fexp));
    chk("first_act", 32'(first_act), 32'(m_fact));
    chk("vec_count4", 32'(vec_count4), m_vec4);
    chk("error_count4", 32'(error_count4), m_err4);
    chk("fail4", 32'(fail4), 32'(md && m_err != 0));
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge.
  task automatic cyc(input logic st, input logic iv, input logic lst,
                     input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] cc,
                     input logic [15:0] ex, input logic [15:0] act);
    logic acc, cmp, any;
    sb_t  sb;
    start = st; in_valid = iv; last = lst; a = aa; b = bb; c = cc;
    acc = iv && !st && (m_state == ST_RUN);
    if (st) begin
      for (int i = 0; i <= int'(L); i++) yline[i] = '0;
      sbq.delete();
    end
    for (int i = int'(L); i > 0; i--) yline[i] = yline[i-1];
    yline[0] = {acc, act};
    if (acc) sbq.push_back({ex, act});
    y = yline[L].act;
    cmp = yline[L].v;
    any = 1'b0;
    for (int i = 1; i <= int'(L); i++) any = any | yline[i].v;
    @(posedge clk);
    if (st) begin
      model_clear(ST_RUN);
    end else begin
      if (cmp) begin
        sb = sbq.pop_front();
        m_vec++;
        if (m_vec4 < 15) m_vec4++;
        if (sb.exp_v != sb.act) begin
          m_err++;
          if (m_err4 < 15) m_err4++;
          if (!m_ferr) begin
            m_ferr = 1'b1; m_fexp = sb.exp_v; m_fact = sb.act;
          end
        end
      end
      if (m_state == ST_RUN && iv && lst) m_state = ST_DRAIN;
      else if (m_state == ST_DRAIN && !any) m_state = ST_DONE;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic go();
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    int lat;
    logic [15:0] s;
    clean_tbl[0] = '{16'h0001, 16'h0002, 16'h0003, 16'h0006, 16'h0000};
    clean_tbl[1] = '{16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h0000};
    clean_tbl[2] = '{16'h1234, 16'h4321, 16'h1111, 16'h6666, 16'h0000};
    strm_tbl[0] = '{16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'h0000};
    strm_tbl[1] = '{16'h00FF, 16'h0001, 16'h0000, 16'h0100, 16'h0000};
    strm_tbl[2] = '{16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0001};
    strm_tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD, 16'h0000};
    strm_tbl[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h6666, 16'h0000};
    strm_tbl[5] = '{16'hAAAA, 16'h5555, 16'h0001, 16'h0000, 16'h8000};
    strm_tbl[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    strm_tbl[7] = '{16'h1000, 16'h2000, 16'h3000, 16'h6000, 16'h0000};

    model_clear(ST_IDLE);
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(2);

    // Single vector
    go();
    cyc(1'b0, 1'b1, 1'b1, 16'h0654, 16'h0456, 16'h0555, 16'h0FFF, 16'h0FFF);
    idle(4);
    chk("single_vec_count", 32'(vec_count), 32'd1);
    chk("single_pass", 32'(pass), 32'd1);

    // Wrap-around, correct then wrongly truncated y
    go();
    cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    idle(4);
    chk("wrap_pass", 32'(pass), 32'd1);
    go();
    cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 16'h0000);
    idle(4);
    chk("wrap_err", 32'(error_count), 32'd1);
    chk("wrap_first_exp", 32'(first_exp), 32'h0001);
    chk("wrap_first_act", 32'(first_act), 32'h0000);
    chk("wrap_fail", 32'(fail), 32'd1);

    // Restart from a failing DONE, clean run with a gap
    go();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_err", 32'(error_count), 32'd0);
    chk("restart_first_exp", 32'(first_exp), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'(i == 2), clean_tbl[i].a, clean_tbl[i].b, clean_tbl[i].c,
          clean_tbl[i].sum, clean_tbl[i].sum ^ clean_tbl[i].mask);
      if (i == 0) idle(1);
    end
    idle(4);
    chk("restart_pass", 32'(pass), 32'd1);
    chk("restart_vec", 32'(vec_count), 32'd3);

    // Streaming 8 back-to-back, corrupt vectors 3 and 6
    go();
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'(i == 7), strm_tbl[i].a, strm_tbl[i].b, strm_tbl[i].c,
          strm_tbl[i].sum, strm_tbl[i].sum ^ strm_tbl[i].mask);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (done) begin lat = k; break; end
    end
    chk("stream_done_latency", 32'(lat), 32'(L + 1));
    chk("stream_vec", 32'(vec_count), 32'd8);
    chk("stream_err", 32'(error_count), 32'd2);
    chk("stream_first_exp", 32'(first_exp), 32'h8000);
    chk("stream_first_act", 32'(first_act), 32'h8001);
    chk("stream_fail", 32'(fail), 32'd1);

    // Async reset mid-run, then vectors without start are ignored
    go();
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b0, strm_tbl[i].a, strm_tbl[i].b, strm_tbl[i].c,
          strm_tbl[i].sum, strm_tbl[i].sum ^ 16'h0001);
    #2 rst_n = 1'b0;
    model_clear(ST_IDLE);
    #1 check_all();
    chk("reset_vec", 32'(vec_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 1'(i == 3), strm_tbl[i].a, strm_tbl[i].b, strm_tbl[i].c,
          strm_tbl[i].sum, strm_tbl[i].sum);
    idle(3);
    chk("post_reset_vec", 32'(vec_count), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Saturation: 20 mismatches
    go();
    for (int i = 0; i < 20; i++) begin
      s = 16'(i) + 16'h0100 + 16'h0010;
      cyc(1'b0, 1'b1, 1'(i == 19), 16'(i), 16'h0100, 16'h0010, s, ~s);
    end
    idle(4);
    chk("sat_err4", 32'(error_count4), 32'hF);
    chk("sat_vec4", 32'(vec_count4), 32'hF);
    chk("sat_fail4", 32'(fail4), 32'd1);
    chk("sat_err16", 32'(error_count), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
